seq_divider: RTL and testbench

- Iterative restoring divider. It is the inverse datapath of the 8x8 multiplier: it divides a 16-bit dividend by an 8-bit divisor and returns a 16-bit quotient and an 8-bit remainder.
- Produces one quotient bit per clock. Each trial subtraction is done as an add: the partial remainder plus the inverted divisor, with carry-in = 1.
- Sits beside the multiplier in the ALU. Uses a start/done handshake toward the ALU control FSM.

---
 rtl/seq_divider_pkg.sv | 46 ++++
 rtl/seq_divider_div_step.sv | 26 ++
 rtl/seq_divider.sv | 109 ++++++++++
 tb/tb_seq_divider.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/seq_divider_pkg.sv
// Shared ALU divider definitions: widths, FSM state encoding, adder helper.
package seq_divider_pkg;

  localparam int DVD_W = 16;
  localparam int DVS_W = 8;
  localparam int CNT_W = 4;
  localparam int P_W   = DVS_W + 1;

  localparam logic [DVD_W-1:0] DIV0_QUOT = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_e;

  // Carry-lookahead adder. Every carry is built from the group
  // generate/propagate terms back to carry-in rather than rippled.
  // Returns {carry_out, sum}.
  function automatic logic [P_W:0] cla_add(input logic [P_W-1:0] a,
                                           input logic [P_W-1:0] b,
                                           input logic           cin);
    logic [P_W-1:0] g;
    logic [P_W-1:0] p;
    logic [P_W:0]   c;
    logic           grp_g;
    logic           grp_p;
    g     = a & b;
    p     = a ^ b;
    c     = '0;
    c[0]  = cin;
    grp_g = 1'b0;
    grp_p = 1'b0;
    for (int i = 0; i < P_W; i++) begin
      grp_g = g[i];
      grp_p = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        grp_g = grp_g | (grp_p & g[j]);
        grp_p = grp_p & p[j];
      end
      c[i+1] = grp_g | (grp_p & cin);
    end
    return {c[P_W], p ^ c[P_W-1:0]};
  endfunction

endpackage

// File: rtl/seq_divider_div_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract the
// divisor, keep the difference only when it did not borrow.
module div_step
  import seq_divider_pkg::*;
(
  input  logic [P_W-1:0]   p_in,
  input  logic             shift_in,
  input  logic [DVS_W-1:0] divisor,
  output logic [P_W-1:0]   p_out,
  output logic             q_bit
);

  logic [P_W-1:0] trial;
  logic [P_W:0]   diff;

  assign trial = {p_in[DVS_W-1:0], shift_in};

  // Subtract as add of the inverted divisor with carry-in 1; carry-out = no borrow.
  assign diff  = cla_add(trial, ~{1'b0, divisor}, 1'b1);

  // p_in[DVS_W] is always 0 since P < divisor; if it were set, the true
  // trial value would exceed any divisor, so the subtraction must be taken.
  assign q_bit = diff[P_W] | p_in[DVS_W];
  assign p_out = q_bit ? diff[P_W-1:0] : trial;

endmodule

// File: rtl/seq_divider.sv
// Iterative restoring divider, 16/8 -> 16 quotient + 8 remainder, one
// quotient bit per clock, start/done handshake toward the ALU control FSM.
//
//   state | meaning
//   IDLE  | ready for start; results held
//   CALC  | one quotient bit per cycle, counter 15 down to 0
//   DONE  | results valid, done pulse for one cycle
module seq_divider
  import seq_divider_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [DVD_W-1:0] dividend,
  input  logic [DVS_W-1:0] divisor,
  output logic             ready,
  output logic             done,
  output logic [DVD_W-1:0] quotient,
  output logic [DVS_W-1:0] remainder,
  output logic             div_by_zero
);

  state_e             state;
  state_e             state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [DVD_W-1:0]   q_r;
  logic [DVS_W-1:0]   dvs_r;
  logic [P_W-1:0]     p_r;
  logic [P_W-1:0]     p_nxt;
  logic               q_bit;
  logic               dvs_zero;

  assign dvs_zero = (divisor == '0);

  div_step u_step (
    .p_in     (p_r),
    .shift_in (q_r[DVD_W-1]),
    .divisor  (dvs_r),
    .p_out    (p_nxt),
    .q_bit    (q_bit)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) state_nxt = dvs_zero ? DONE : CALC;
      end
      CALC: begin
        if (cnt == '0) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: operand capture, shift/subtract iterations, result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      q_r         <= '0;
      dvs_r       <= '0;
      p_r         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start && !dvs_zero) begin
            q_r   <= dividend;
            dvs_r <= divisor;
            p_r   <= '0;
            cnt   <= CNT_W'(DVD_W - 1);
          end else if (start) begin
            quotient    <= DIV0_QUOT;
            remainder   <= dividend[DVS_W-1:0];
            div_by_zero <= 1'b1;
          end
        end
        CALC: begin
          q_r <= {q_r[DVD_W-2:0], q_bit};
          p_r <= p_nxt;
          cnt <= cnt - 1'b1;
          if (cnt == '0) begin
            quotient    <= {q_r[DVD_W-2:0], q_bit};
            remainder   <= p_nxt[DVS_W-1:0];
            div_by_zero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed cases plus random divides,
// expected results queued at start and compared when done pulses.
module tb_seq_divider;
  import seq_divider_pkg::*;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [DVD_W-1:0] dividend;
  logic [DVS_W-1:0] divisor;
  logic             ready;
  logic             done;
  logic [DVD_W-1:0] quotient;
  logic [DVS_W-1:0] remainder;
  logic             div_by_zero;

  typedef struct packed {
    logic [DVD_W-1:0] q;
    logic [DVS_W-1:0] r;
    logic             z;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  seq_divider dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .ready       (ready),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t model(input logic [DVD_W-1:0] a, input logic [DVS_W-1:0] b);
    exp_t e;
    if (b == '0) begin
      e.q = 16'hFFFF;
      e.r = a[7:0];
      e.z = 1'b1;
    end else begin
      e.q = a / {8'h00, b};
      e.r = 8'(a % {8'h00, b});
      e.z = 1'b0;
    end
    return e;
  endfunction

  // One divide: wait ready, pulse start, wait for done, compare against the queue.
  // busy_at >= 0 injects a start (50/3) at that cycle of CALC.
  task automatic run_div(input logic [DVD_W-1:0] a, input logic [DVS_W-1:0] b,
                         input int busy_at);
    int   w;
    int   lat;
    exp_t e;
    logic [24:0] prev;
    w = 0;
    while (!ready && w < 50) begin
      tick();
      w++;
    end
    check_eq("ready_before_start", 32'(ready), 32'd1);
    prev     = {quotient, remainder, div_by_zero};
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    sb.push_back(model(a, b));
    tick();
    start    = 1'b0;
    dividend = 16'($urandom);
    divisor  = 8'($urandom);
    lat = 0;
    while (!done && lat < 40) begin
      if (lat == busy_at) begin
        start    = 1'b1;
        dividend = 16'd50;
        divisor  = 8'd3;
      end else begin
        start = 1'b0;
      end
      tick();
      lat++;
      if (lat == 8) check_eq("hold_during_calc", 32'({quotient, remainder, div_by_zero}), 32'(prev));
      if (lat == busy_at + 1) check_eq("busy_not_ready", 32'(ready), 32'd0);
    end
    start = 1'b0;
    check_eq("latency", lat, (b == '0) ? 0 : 16);
    if (sb.size() == 0) begin
      check_eq("sb_empty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check_eq("quotient", 32'(quotient), 32'(e.q));
      check_eq("remainder", 32'(remainder), 32'(e.r));
      check_eq("div_by_zero", 32'(div_by_zero), 32'(e.z));
    end
    tick();
    check_eq("done_one_cycle", 32'(done), 32'd0);
    check_eq("ready_after_done", 32'(ready), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic saw_done;
    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    tick();
    tick();
    rst = 1'b0;
    check_eq("rst_ready", 32'(ready), 32'd1);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_quotient", 32'(quotient), 32'd0);
    check_eq("rst_remainder", 32'(remainder), 32'd0);
    check_eq("rst_dbz", 32'(div_by_zero), 32'd0);

    run_div(16'd100, 8'd7, -1);
    run_div(16'hFFFF, 8'd1, -1);
    run_div(16'hFFFF, 8'hFF, -1);
    run_div(16'd0, 8'd5, -1);
    run_div(16'h04D2, 8'd0, -1);

    // Results hold in IDLE.
    for (int i = 0; i < 3; i++) tick();
    check_eq("idle_hold", 32'({quotient, remainder, div_by_zero}), 32'({16'hFFFF, 8'hD2, 1'b1}));

    run_div(16'd100, 8'd7, 4);

    // Reset abort mid-CALC; start coinciding with rst must be ignored.
    dividend = 16'd1000;
    divisor  = 8'd9;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done) saw_done = 1'b1;
    end
    rst      = 1'b1;
    start    = 1'b1;
    dividend = 16'd7;
    divisor  = 8'd0;
    tick();
    if (done) saw_done = 1'b1;
    rst   = 1'b0;
    start = 1'b0;
    sb.delete();
    check_eq("abort_no_done", 32'(saw_done), 32'd0);
    check_eq("abort_ready", 32'(ready), 32'd1);
    check_eq("abort_outputs", 32'({quotient, remainder, div_by_zero}), 32'd0);
    tick();
    check_eq("abort_still_idle", 32'(ready), 32'd1);
    check_eq("abort_no_dbz", 32'(div_by_zero), 32'd0);

    run_div(16'd1000, 8'd9, -1);

    for (int i = 0; i < 2000; i++) begin
      run_div(16'($urandom), 8'($urandom_range(1, 255)), -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
